axi_slave_mem: RTL and testbench

AXI4 slave responder backed by an on-chip word memory; the responder-side counterpart to the AXI master driven by the verification environment. It accepts one write burst and one read burst at a time on independent channels and supports FIXED, INCR and WRAP bursts with byte strobes. It is the default DUT/target sitting on the `s_axi_*` bus in block-level and environment regressions.

---
 rtl/axi_slave_mem.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem
//  Brief    : AXI4 slave responder backed by an on-chip word memory. One write
//             burst and one read burst in flight at a time on independent
//             channels; FIXED / INCR / WRAP bursts with byte strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 8,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   // write address channel
   input  logic [ID_WIDTH-1:0]   s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   // write response channel
   output logic [ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   // read address channel
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   // read data channel
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int                    c_OFF_W  = $clog2(STRB_WIDTH);
   localparam int                    c_IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [2:0]            c_SIZE   = 3'(c_OFF_W);
   localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] c_STEP   = ADDR_WIDTH'(STRB_WIDTH);
   localparam logic [1:0]            c_FIXED  = 2'b00;
   localparam logic [1:0]            c_INCR   = 2'b01;
   localparam logic [1:0]            c_WRAP   = 2'b10;
   localparam logic [1:0]            c_OKAY   = 2'b00;
   localparam logic [1:0]            c_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   // Next beat address for the given burst type; wrap bound is (len+1) beats.
   function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0]            len,
      input logic [1:0]            burst
   );
      logic [ADDR_WIDTH-1:0] inc_addr;
      logic [ADDR_WIDTH-1:0] wrap_mask;
      inc_addr  = addr + c_STEP;
      wrap_mask = ((ADDR_WIDTH'(len) + c_ONE) << c_OFF_W) - c_ONE;
      case (burst)
         c_FIXED: f_next_addr = addr;
         c_INCR:  f_next_addr = inc_addr;
         c_WRAP:  f_next_addr = (addr & ~wrap_mask) | (inc_addr & wrap_mask);
         default: f_next_addr = addr;
      endcase
   endfunction

   // Unsupported burst encodings, narrow transfers and illegal wrap lengths.
   function automatic logic f_bad(
      input logic [1:0] burst,
      input logic [2:0] size,
      input logic [7:0] len
   );
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      f_bad = (burst == 2'b11) || (size != c_SIZE) || ((burst == c_WRAP) && !wrap_len_ok);
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

   // ------------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------------
   wstate_t               r_wstate;
   wstate_t               w_wstate_nxt;
   logic [ID_WIDTH-1:0]   r_awid;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [7:0]            r_wlen;
   logic [1:0]            r_wburst;
   logic [7:0]            r_wcnt;
   logic                  r_wcfg_err;
   logic                  r_wlast_err;
   logic                  w_awready;
   logic                  w_wready;
   logic                  w_bvalid;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic [c_IDX_W-1:0]    w_widx;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   // Write FSM next state and handshake outputs; all held low in reset.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_awready    = 1'b0;
      w_wready     = 1'b0;
      w_bvalid     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_awready = 1'b1;
            if (s_axi_awvalid) w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            w_wready = 1'b1;
            if (s_axi_wvalid && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            w_bvalid = 1'b1;
            if (s_axi_bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
      if (rst) begin
         w_awready = 1'b0;
         w_wready  = 1'b0;
         w_bvalid  = 1'b0;
      end
   end

   assign w_aw_hs = w_awready & s_axi_awvalid;
   assign w_w_hs  = w_wready & s_axi_wvalid;
   assign w_widx  = r_waddr[c_OFF_W +: c_IDX_W];

   // Latch the write burst and step address/count on every accepted beat.
   // The beat count alone decides the end of the burst; wlast only flags errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_awid      <= '0;
         r_waddr     <= '0;
         r_wlen      <= '0;
         r_wburst    <= '0;
         r_wcnt      <= '0;
         r_wcfg_err  <= 1'b0;
         r_wlast_err <= 1'b0;
      end else if (w_aw_hs) begin
         r_awid      <= s_axi_awid;
         r_waddr     <= s_axi_awaddr;
         r_wlen      <= s_axi_awlen;
         r_wburst    <= s_axi_awburst;
         r_wcnt      <= '0;
         r_wcfg_err  <= f_bad(s_axi_awburst, s_axi_awsize, s_axi_awlen);
         r_wlast_err <= 1'b0;
      end else if (w_w_hs) begin
         if (s_axi_wlast != (r_wcnt == r_wlen)) r_wlast_err <= 1'b1;
         if (r_wcnt != r_wlen) begin
            r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
         end
      end
   end

   // Byte-enabled memory write; a misconfigured burst never touches memory.
   always_ff @(posedge clk) begin
      if (w_w_hs && !r_wcfg_err) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (s_axi_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
   end

   assign s_axi_awready = w_awready;
   assign s_axi_wready  = w_wready;
   assign s_axi_bvalid  = w_bvalid;
   assign s_axi_bid     = r_awid;
   assign s_axi_bresp   = (r_wcfg_err | r_wlast_err) ? c_SLVERR : c_OKAY;

   // ------------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------------
   rstate_t               r_rstate;
   rstate_t               w_rstate_nxt;
   logic [ID_WIDTH-1:0]   r_arid;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [7:0]            r_rlen;
   logic [1:0]            r_rburst;
   logic [7:0]            r_rcnt;
   logic                  r_rerr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rlast;
   logic                  w_arready;
   logic                  w_rvalid;
   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic [c_IDX_W-1:0]    w_ridx;

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   // Read FSM next state and handshake outputs; all held low in reset.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_arready    = 1'b0;
      w_rvalid     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready = 1'b1;
            if (s_axi_arvalid) w_rstate_nxt = R_FETCH;
         end
         R_FETCH: w_rstate_nxt = R_DATA;
         R_DATA: begin
            w_rvalid = 1'b1;
            if (s_axi_rready) w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
      if (rst) begin
         w_arready = 1'b0;
         w_rvalid  = 1'b0;
      end
   end

   assign w_ar_hs = w_arready & s_axi_arvalid;
   assign w_r_hs  = w_rvalid & s_axi_rready;
   assign w_ridx  = r_raddr[c_OFF_W +: c_IDX_W];

   // Latch the read burst, fetch one word per beat (old data on a same-cycle
   // write) and step address/count after each non-final R handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_arid   <= '0;
         r_raddr  <= '0;
         r_rlen   <= '0;
         r_rburst <= '0;
         r_rcnt   <= '0;
         r_rerr   <= 1'b0;
         r_rdata  <= '0;
         r_rlast  <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_arid   <= s_axi_arid;
            r_raddr  <= s_axi_araddr;
            r_rlen   <= s_axi_arlen;
            r_rburst <= s_axi_arburst;
            r_rcnt   <= '0;
            r_rerr   <= f_bad(s_axi_arburst, s_axi_arsize, s_axi_arlen);
         end
         if (r_rstate == R_FETCH) begin
            r_rdata <= r_rerr ? '0 : r_mem[w_ridx];
            r_rlast <= (r_rcnt == r_rlen);
         end
         if (w_r_hs && !r_rlast) begin
            r_raddr <= f_next_addr(r_raddr, r_rlen, r_rburst);
            r_rcnt  <= r_rcnt + 8'd1;
         end
      end
   end

   assign s_axi_arready = w_arready;
   assign s_axi_rvalid  = w_rvalid;
   assign s_axi_rid     = r_arid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rresp   = r_rerr ? c_SLVERR : c_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_slave_mem
//  Brief    : Self-checking bench for axi_slave_mem; expected B/R responses
//             are queued when bursts are issued and compared on handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_axi_awid = '0;
   logic [15:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [7:0]  s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [7:0]  s_axi_arid = '0;
   logic [15:0] s_axi_araddr = '0;
   logic [7:0]  s_axi_arlen = '0;
   logic [2:0]  s_axi_arsize = '0;
   logic [1:0]  s_axi_arburst = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [7:0]  s_axi_rid;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b1;

   always #5 clk = ~clk;

   axi_slave_mem dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   typedef struct {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } exp_t;

   exp_t        bq[$];
   exp_t        rq[$];
   logic [31:0] model [0:1023];
   logic [31:0] wd [0:255];
   logic [3:0]  ws [0:255];
   int          n_chk  = 0;
   int          n_err  = 0;
   int          b_seen = 0;
   int          r_seen = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic cfg_err(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [7:0] len);
      return (burst == 2'b11) || (size != 3'd2) ||
             ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   function automatic int widx(input logic [15:0] a);
      return (int'(a) / 4) % 1024;
   endfunction

   // Independent address model: wrap computed as offset within an aligned window.
   function automatic logic [15:0] nxt(input logic [15:0] a, input logic [7:0] len,
                                       input logic [1:0] burst);
      int bound, base;
      case (burst)
         2'b00: return a;
         2'b10: begin
            bound = (int'(len) + 1) * 4;
            base  = (int'(a) / bound) * bound;
            return 16'(base + ((int'(a) - base + 4) % bound));
         end
         default: return a + 16'd4;
      endcase
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at);
      logic        bad;
      logic [15:0] a;
      int          cyc;
      int          b0;
      exp_t        e;
      bad = cfg_err(burst, size, len);
      a   = addr;
      b0  = b_seen;
      @(posedge clk); #1;
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
      s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!s_axi_awready && cyc < 100) begin @(negedge clk); cyc++; end
      chk("awready", s_axi_awready, 1'b1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
         s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
         cyc = 0;
         @(negedge clk);
         while (!s_axi_wready && cyc < 100) begin @(negedge clk); cyc++; end
         chk("wready", s_axi_wready, 1'b1);
         if (!bad) model_write(a, wd[i], ws[i]);
         if (i == int'(len)) begin
            e.id   = id;
            e.resp = (bad || last_at != int'(len)) ? 2'b10 : 2'b00;
            e.data = '0;
            e.last = 1'b0;
            bq.push_back(e);
         end
         a = nxt(a, len, burst);
         @(posedge clk); #1;
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      cyc = 0;
      while (b_seen == b0 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("b_done", b_seen - b0, 1);
   endtask

   task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      logic        bad;
      logic [15:0] a;
      int          cyc;
      int          r0;
      exp_t        e;
      bad = cfg_err(burst, size, len);
      a   = addr;
      r0  = r_seen;
      @(posedge clk); #1;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!s_axi_arready && cyc < 100) begin @(negedge clk); cyc++; end
      chk("arready", s_axi_arready, 1'b1);
      for (int i = 0; i <= int'(len); i++) begin
         e.id   = id;
         e.data = bad ? 32'h0 : model[widx(a)];
         e.resp = bad ? 2'b10 : 2'b00;
         e.last = (i == int'(len));
         rq.push_back(e);
         a = nxt(a, len, burst);
      end
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      cyc = 0;
      while ((r_seen - r0) < int'(len) + 1 && cyc < 4 * int'(len) + 100) begin
         @(negedge clk); cyc++;
      end
      chk("r_done", r_seen - r0, int'(len) + 1);
   endtask

   // Scoreboard: compare each B/R handshake against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && s_axi_bvalid && s_axi_bready) begin
         chk("b_queued", bq.size() > 0, 1'b1);
         if (bq.size() > 0) begin
            e = bq.pop_front();
            chk("bid", s_axi_bid, e.id);
            chk("bresp", s_axi_bresp, e.resp);
         end
         b_seen++;
      end
      if (!rst && s_axi_rvalid && s_axi_rready) begin
         chk("r_queued", rq.size() > 0, 1'b1);
         if (rq.size() > 0) begin
            e = rq.pop_front();
            chk("rid", s_axi_rid, e.id);
            chk("rdata", s_axi_rdata, e.data);
            chk("rresp", s_axi_rresp, e.resp);
            chk("rlast", s_axi_rlast, e.last);
         end
         r_seen++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      int cyc;

      // ---------------- power-on reset ----------------
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("reset_outputs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                               s_axi_rvalid, s_axi_rlast, s_axi_bid, s_axi_bresp,
                               s_axi_rid, s_axi_rresp, s_axi_rdata}, 64'h0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("awready_after_reset", s_axi_awready, 1'b1);
      chk("arready_after_reset", s_axi_arready, 1'b1);

      // ---------------- 256-beat fill and read-back ----------------
      for (int i = 0; i < 256; i++) begin
         wd[i] = {8'h5A, 8'(i), 16'(i * 3 + 7)};
         ws[i] = 4'hF;
      end
      do_write(8'h01, 16'h0000, 8'd255, 2'b01, 3'd2, 255);
      do_read (8'h02, 16'h0000, 8'd255, 2'b01, 3'd2);

      // ---------------- INCR ----------------
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
      do_write(8'h05, 16'h0010, 8'd3, 2'b01, 3'd2, 3);
      do_read (8'h07, 16'h0010, 8'd3, 2'b01, 3'd2);

      // ---------------- strobes ----------------
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(8'h10, 16'h0040, 8'd0, 2'b01, 3'd2, 0);
      wd[0] = 32'h00001234; ws[0] = 4'b0011;
      do_write(8'h11, 16'h0040, 8'd0, 2'b01, 3'd2, 0);
      chk("strobe_model", model[16], 32'hDEAD1234);
      do_read (8'h12, 16'h0040, 8'd0, 2'b01, 3'd2);

      // ---------------- WRAP ----------------
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
      do_write(8'h09, 16'h0018, 8'd3, 2'b10, 3'd2, 3);
      do_read (8'h0A, 16'h0018, 8'd3, 2'b10, 3'd2);
      do_read (8'h0B, 16'h0010, 8'd3, 2'b01, 3'd2);
      for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0DE0000 + i; ws[i] = 4'hF; end
      do_write(8'h0C, 16'h0020, 8'd2, 2'b10, 3'd2, 2);
      do_read (8'h0D, 16'h0020, 8'd2, 2'b01, 3'd2);

      // ---------------- error cases ----------------
      for (int i = 0; i < 2; i++) begin wd[i] = 32'hEEEE0000 + i; ws[i] = 4'hF; end
      do_write(8'h0E, 16'h0030, 8'd1, 2'b11, 3'd2, 1);
      do_read (8'h0F, 16'h0030, 8'd1, 2'b01, 3'd2);
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h77770000 + i; ws[i] = 4'hF; end
      do_write(8'h20, 16'h0050, 8'd3, 2'b01, 3'd2, 1);
      do_read (8'h21, 16'h0010, 8'd3, 2'b01, 3'd1);

      // ---------------- backpressure on B ----------------
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h60600000 + i; ws[i] = 4'hF; end
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
      fork
         do_write(8'h23, 16'h0060, 8'd3, 2'b01, 3'd2, 3);
         begin
            cyc = 0;
            @(negedge clk);
            while (!s_axi_bvalid && cyc < 100) begin @(negedge clk); cyc++; end
            chk("bvalid_stall_start", s_axi_bvalid, 1'b1);
            repeat (3) begin
               @(negedge clk);
               chk("bvalid_held", s_axi_bvalid, 1'b1);
               if (bq.size() > 0) chk("bid_held", s_axi_bid, bq[0].id);
            end
            @(posedge clk); #1;
            s_axi_bready = 1'b1;
         end
      join

      // ---------------- backpressure on R mid-burst ----------------
      base = r_seen;
      fork
         do_read(8'h24, 16'h0060, 8'd3, 2'b01, 3'd2);
         begin
            cyc = 0;
            while (r_seen < base + 1 && cyc < 100) begin @(negedge clk); cyc++; end
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
            cyc = 0;
            @(negedge clk);
            while (!s_axi_rvalid && cyc < 100) begin @(negedge clk); cyc++; end
            chk("rvalid_stall_start", s_axi_rvalid, 1'b1);
            repeat (5) begin
               @(negedge clk);
               chk("rvalid_held", s_axi_rvalid, 1'b1);
               if (rq.size() > 0) chk("rdata_held", s_axi_rdata, rq[0].data);
            end
            @(posedge clk); #1;
            s_axi_rready = 1'b1;
         end
      join

      // ---------------- concurrent read and write ----------------
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h80800000 + i; ws[i] = 4'hF; end
      fork
         do_write(8'h31, 16'h0080, 8'd3, 2'b01, 3'd2, 3);
         do_read (8'h32, 16'h0020, 8'd3, 2'b01, 3'd2);
      join
      do_read(8'h33, 16'h0080, 8'd3, 2'b01, 3'd2);

      // ---------------- reset mid-burst ----------------
      @(posedge clk); #1;
      s_axi_awid = 8'h03; s_axi_awaddr = 16'h0C00; s_axi_awlen = 8'd7;
      s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      s_axi_wvalid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("midburst_reset_outputs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                        s_axi_rvalid, s_axi_rlast, s_axi_bid, s_axi_bresp,
                                        s_axi_rid, s_axi_rresp, s_axi_rdata}, 64'h0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("awready_after_rerst", s_axi_awready, 1'b1);
      chk("arready_after_rerst", s_axi_arready, 1'b1);
      chk("no_pending_b", bq.size(), 0);
      for (int i = 0; i < 2; i++) begin wd[i] = 32'h44440000 + i; ws[i] = 4'hF; end
      do_write(8'h44, 16'h00C0, 8'd1, 2'b01, 3'd2, 1);
      do_read (8'h45, 16'h00C0, 8'd1, 2'b01, 3'd2);

      repeat (4) @(posedge clk);
      chk("rq_drained", rq.size(), 0);
      chk("bq_drained", bq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
